// File: rtl/hazard_ctrl.sv
// hazard_ctrl: ID-side pipeline sequencer for load-use stalls, EX redirects and memory-wait freezes
module hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [6:0]       id_opcode,
  input  logic [4:0]       id_rs1_addr,
  input  logic [4:0]       id_rs2_addr,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd_addr,
  input  logic             ex_redirect,
  input  logic [31:0]      ex_redirect_pc,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             imm_type,
  output logic             pc_write,
  output logic             pc_redir_valid,
  output logic [31:0]      pc_redir,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_freeze,
  output logic             memwb_bubble,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);
  typedef enum logic {RUN, DWAIT} state_t;
  state_t           state_q, state_d;
  logic             redir_pend_q, redir_pend_d;
  logic [31:0]      redir_pc_q, redir_pc_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic             use_rs1, use_rs2, load_use;
  logic             run, dstall, freeze, redir, lu, im;
  logic [31:0]      target;
  assign imm_type = id_opcode inside {7'b0000011, 7'b0010011, 7'b0100011, 7'b1100011,
                                      7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
  assign use_rs1  = !(id_opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
  assign use_rs2  = id_opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
  assign load_use = id_valid & ex_mem_read & (ex_rd_addr != 5'd0) &
                    ((use_rs1 & (id_rs1_addr == ex_rd_addr)) | (use_rs2 & (id_rs2_addr == ex_rd_addr)));
  always_comb begin
    run            = state_q == RUN;
    dstall         = dmem_req & !dmem_ready;
    freeze         = run ? dstall : !dmem_ready;
    redir          = run ? (!dstall & ex_redirect) : (dmem_ready & redir_pend_q);
    target         = run ? ex_redirect_pc : redir_pc_q;
    lu             = !freeze & !redir & load_use;
    im             = !freeze & !redir & !load_use & !imem_ready;
    pc_write       = !(freeze | lu | im);
    ifid_write     = !(freeze | lu);
    ifid_flush     = redir | im;
    idex_flush     = redir | lu;
    pipe_freeze    = freeze;
    memwb_bubble   = freeze;
    pc_redir_valid = redir;
    pc_redir       = redir ? target : 32'd0;
    state_d        = run ? (dstall ? DWAIT : RUN) : (dmem_ready ? RUN : DWAIT);
    redir_pend_d   = (run & dstall & ex_redirect) ? 1'b1 : (!run & dmem_ready) ? 1'b0 : redir_pend_q;
    redir_pc_d     = (run & dstall & ex_redirect) ? ex_redirect_pc : redir_pc_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= 32'd0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
      if (!pc_write && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redir && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed self-checking bench for hazard_ctrl
module tb_hazard_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic [6:0]  id_opcode;
  logic [4:0]  id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic        ex_mem_read, ex_redirect, imem_ready, dmem_req, dmem_ready;
  logic [31:0] ex_redirect_pc;
  logic        imm_type, pc_write, pc_redir_valid, ifid_write, ifid_flush, idex_flush, pipe_freeze, memwb_bubble;
  logic [31:0] pc_redir, stall_cnt, flush_cnt;
  logic        s_imm_type, s_pc_write, s_pc_redir_valid, s_ifid_write, s_ifid_flush, s_idex_flush, s_pipe_freeze, s_memwb_bubble;
  logic [31:0] s_pc_redir;
  logic [1:0]  s_stall_cnt, s_flush_cnt;
  logic [6:0]  ctl;
  int          checks = 0;
  int          failures = 0;
  localparam logic [6:0] DEF = 7'b1100000, LU = 7'b0001000, RD = 7'b1111001, FRZ = 7'b0000110, IM = 7'b0110000;
  localparam logic [6:0] ADD = 7'b0110011, LUI = 7'b0110111;
  always #5 clk = ~clk;
  assign ctl = {pc_write, ifid_write, ifid_flush, idex_flush, pipe_freeze, memwb_bubble, pc_redir_valid};
  hazard_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .imm_type(imm_type), .pc_write(pc_write), .pc_redir_valid(pc_redir_valid), .pc_redir(pc_redir),
    .ifid_write(ifid_write), .ifid_flush(ifid_flush), .idex_flush(idex_flush), .pipe_freeze(pipe_freeze),
    .memwb_bubble(memwb_bubble), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );
  hazard_ctrl #(.CNT_W(2)) sat (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode), .id_rs1_addr(id_rs1_addr),
    .id_rs2_addr(id_rs2_addr), .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_redirect(ex_redirect),
    .ex_redirect_pc(ex_redirect_pc), .imem_ready(imem_ready), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .imm_type(s_imm_type), .pc_write(s_pc_write), .pc_redir_valid(s_pc_redir_valid), .pc_redir(s_pc_redir),
    .ifid_write(s_ifid_write), .ifid_flush(s_ifid_flush), .idex_flush(s_idex_flush), .pipe_freeze(s_pipe_freeze),
    .memwb_bubble(s_memwb_bubble), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );
  task automatic idle();
    rst = 0; id_valid = 0; id_opcode = ADD; id_rs1_addr = 0; id_rs2_addr = 0; ex_mem_read = 0; ex_rd_addr = 0;
    ex_redirect = 0; ex_redirect_pc = 0; imem_ready = 1; dmem_req = 0; dmem_ready = 0;
  endtask
  task automatic test_reset();
    idle(); rst = 1;
    @(negedge clk); @(negedge clk);
    rst = 0; #1;
    checks++; if (ctl !== DEF) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    checks++; if (pc_redir !== 0) begin failures++; $display("FAIL reset_pc_redir got=%h exp=0", pc_redir); end
  endtask
  task automatic test_load_use();
    @(negedge clk); idle();
    id_valid = 1; id_opcode = ADD; id_rs1_addr = 5; id_rs2_addr = 1; ex_mem_read = 1; ex_rd_addr = 5; #1;
    checks++; if (ctl !== LU) begin failures++; $display("FAIL load_use_ctl got=%b exp=%b", ctl, LU); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_cnt !== 1) begin failures++; $display("FAIL load_use_stall_cnt got=%0d exp=1", stall_cnt); end
    checks++; if (ctl !== DEF) begin failures++; $display("FAIL load_use_after got=%b exp=%b", ctl, DEF); end
    id_valid = 1; id_opcode = ADD; id_rs1_addr = 3; id_rs2_addr = 7; ex_mem_read = 1; ex_rd_addr = 7; #1;
    checks++; if (ctl !== LU) begin failures++; $display("FAIL load_use_rs2 got=%b exp=%b", ctl, LU); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_cnt !== 2) begin failures++; $display("FAIL load_use_rs2_cnt got=%0d exp=2", stall_cnt); end
  endtask
  task automatic test_no_stall();
    id_valid = 1; id_opcode = ADD; id_rs1_addr = 0; id_rs2_addr = 0; ex_mem_read = 1; ex_rd_addr = 0; #1;
    checks++; if (ctl !== DEF) begin failures++; $display("FAIL x0_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (imm_type !== 0) begin failures++; $display("FAIL add_imm_type got=%b exp=0", imm_type); end
    id_opcode = LUI; id_rs1_addr = 5; id_rs2_addr = 5; ex_rd_addr = 5; #1;
    checks++; if (ctl !== DEF) begin failures++; $display("FAIL lui_ctl got=%b exp=%b", ctl, DEF); end
    checks++; if (imm_type !== 1) begin failures++; $display("FAIL lui_imm_type got=%b exp=1", imm_type); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_cnt !== 2) begin failures++; $display("FAIL no_stall_cnt got=%0d exp=2", stall_cnt); end
  endtask
  task automatic test_redirect();
    ex_redirect = 1; ex_redirect_pc = 32'h100; #1;
    checks++; if (ctl !== RD) begin failures++; $display("FAIL redirect_ctl got=%b exp=%b", ctl, RD); end
    checks++; if (pc_redir !== 32'h100) begin failures++; $display("FAIL redirect_pc got=%h exp=00000100", pc_redir); end
    @(negedge clk); idle(); #1;
    checks++; if (flush_cnt !== 1) begin failures++; $display("FAIL redirect_flush_cnt got=%0d exp=1", flush_cnt); end
    checks++; if (pc_redir !== 0) begin failures++; $display("FAIL redirect_pc_idle got=%h exp=0", pc_redir); end
  endtask
  task automatic test_dmem_wait();
    dmem_req = 1; dmem_ready = 0; ex_redirect = 1; ex_redirect_pc = 32'h200; #1;
    checks++; if (ctl !== FRZ || pc_redir !== 0) begin failures++; $display("FAIL dwait_c1 got=%b/%h exp=%b/0", ctl, pc_redir, FRZ); end
    for (int i = 2; i <= 3; i++) begin
      @(negedge clk); ex_redirect = 1; ex_redirect_pc = 32'h300; #1;
      checks++; if (ctl !== FRZ || pc_redir !== 0) begin failures++; $display("FAIL dwait_c%0d got=%b/%h exp=%b/0", i, ctl, pc_redir, FRZ); end
    end
    @(negedge clk); ex_redirect = 0; ex_redirect_pc = 0; dmem_ready = 1; #1;
    checks++; if (ctl !== RD) begin failures++; $display("FAIL dwait_release_ctl got=%b exp=%b", ctl, RD); end
    checks++; if (pc_redir !== 32'h200) begin failures++; $display("FAIL dwait_release_pc got=%h exp=00000200", pc_redir); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_cnt !== 5) begin failures++; $display("FAIL dwait_stall_cnt got=%0d exp=5", stall_cnt); end
    checks++; if (flush_cnt !== 2) begin failures++; $display("FAIL dwait_flush_cnt got=%0d exp=2", flush_cnt); end
    checks++; if (ctl !== DEF) begin failures++; $display("FAIL dwait_after got=%b exp=%b", ctl, DEF); end
  endtask
  task automatic test_priority();
    id_valid = 1; id_opcode = ADD; id_rs1_addr = 9; ex_mem_read = 1; ex_rd_addr = 9; imem_ready = 0; #1;
    checks++; if (ctl !== LU) begin failures++; $display("FAIL prio_lu_imem got=%b exp=%b", ctl, LU); end
    ex_redirect = 1; ex_redirect_pc = 32'h40; #1;
    checks++; if (ctl !== RD || pc_redir !== 32'h40) begin failures++; $display("FAIL prio_redir_lu got=%b/%h exp=%b/00000040", ctl, pc_redir, RD); end
    @(negedge clk); idle(); imem_ready = 0; #1;
    checks++; if (ctl !== IM) begin failures++; $display("FAIL prio_imem got=%b exp=%b", ctl, IM); end
    @(negedge clk); idle(); #1;
    checks++; if (stall_cnt !== 6 || flush_cnt !== 3) begin failures++; $display("FAIL prio_cnt got=%0d/%0d exp=6/3", stall_cnt, flush_cnt); end
  endtask
  task automatic test_reset_in_dwait();
    dmem_req = 1; ex_redirect = 1; ex_redirect_pc = 32'h300;
    @(negedge clk); ex_redirect = 0; rst = 1;
    @(negedge clk); idle(); dmem_ready = 1; #1;
    checks++; if (ctl !== DEF || pc_redir !== 0) begin failures++; $display("FAIL rst_dwait_ctl got=%b/%h exp=%b/0", ctl, pc_redir, DEF); end
    checks++; if (stall_cnt !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL rst_dwait_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
    @(negedge clk); #1;
    checks++; if (pc_redir_valid !== 0 || flush_cnt !== 0) begin failures++; $display("FAIL rst_dwait_dropped got=%b/%0d exp=0/0", pc_redir_valid, flush_cnt); end
  endtask
  task automatic test_saturation();
    for (int i = 0; i < 5; i++) begin imem_ready = 0; @(negedge clk); end
    idle(); #1;
    checks++; if (s_stall_cnt !== 2'b11) begin failures++; $display("FAIL sat_stall got=%0d exp=3", s_stall_cnt); end
    checks++; if (stall_cnt !== 5) begin failures++; $display("FAIL wide_stall got=%0d exp=5", stall_cnt); end
    for (int i = 0; i < 4; i++) begin ex_redirect = 1; ex_redirect_pc = 32'h80; @(negedge clk); end
    idle(); #1;
    checks++; if (s_flush_cnt !== 2'b11) begin failures++; $display("FAIL sat_flush got=%0d exp=3", s_flush_cnt); end
    checks++; if (flush_cnt !== 4) begin failures++; $display("FAIL wide_flush got=%0d exp=4", flush_cnt); end
  endtask
  initial begin
    test_reset();
    test_load_use();
    test_no_stall();
    test_redirect();
    test_dmem_wait();
    test_priority();
    test_reset_in_dwait();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
